// File: rtl/uart_msg_pkg.sv
// uart_msg_pkg: message codes, CRC8 helper and rx parser states shared by the parser and response builder
package uart_msg_pkg;

    localparam logic [7:0] BYTE_HEADER = 8'h5A;
    localparam logic [7:0] CMD_THETA   = 8'hD1;
    localparam logic [7:0] CMD_BURST   = 8'hD2;
    localparam logic [7:0] CMD_DISABLE = 8'hE1;
    localparam logic [7:0] CMD_ENABLE  = 8'hE2;
    localparam logic [7:0] CRC8_POLY   = 8'h9B;

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_BURST, ST_THETA, ST_CRC, ST_CHECK} rx_state_e;

    // MSB-first, unreflected, no final XOR
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        return c;
    endfunction

endpackage

// File: rtl/uart_rx_msg_parser_if.sv
// uart_rx_msg_parser_if: byte stream from the UART receiver into the message parser
interface uart_rx_msg_parser_if;

    logic [7:0] rx_byte;
    logic       rx_byte_valid;

    modport master (output rx_byte, rx_byte_valid);
    modport slave  (input  rx_byte, rx_byte_valid);

endinterface

// File: rtl/uart_rx_msg_parser.sv
// uart_rx_msg_parser: frames 5A/cmd/payload/CRC8 messages and issues command, burst and theta operands
module uart_rx_msg_parser
    import uart_msg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int THETA_BYTES    = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    uart_rx_msg_parser_if.slave      rx_if,
    output logic [7:0]               o_cmd_reg,
    output logic                     o_cmd_valid,
    output logic [7:0]               o_burst_cnt,
    output logic                     o_burst_cnt_valid,
    output logic [8*THETA_BYTES-1:0] o_theta,
    output logic                     o_theta_valid,
    output logic                     o_cordic_en,
    output logic                     o_rx_msg_err
);

    localparam int THW = 8 * THETA_BYTES;
    localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW  = $clog2(THETA_BYTES) + 1;

    rx_state_e        r_state, w_state;
    logic [7:0]       r_crc, w_crc, r_cmd, w_cmd, r_burst, w_burst, r_rx_crc, w_rx_crc;
    logic [THW-1:0]   r_shift, w_shift, r_theta, w_theta;
    logic [CW-1:0]    r_cnt, w_cnt;
    logic [TMW-1:0]   r_timer, w_timer;
    logic             r_pend_valid, w_pend_valid;
    logic [7:0]       r_pend_byte, w_pend_byte;
    logic [7:0]       r_cmd_reg, w_cmd_reg, r_burst_cnt, w_burst_cnt;
    logic             r_cmd_valid, w_cmd_valid, r_burst_valid, w_burst_valid;
    logic             r_theta_valid, w_theta_valid, r_cordic_en, w_cordic_en, r_err, w_err;
    logic             w_valid, w_busy, w_timeout, w_is_d, w_accept;
    logic [7:0]       w_byte, w_crc_next;

    // A strobe landing in CHECK is parked one cycle and replayed from IDLE
    assign w_valid    = rx_if.rx_byte_valid | r_pend_valid;
    assign w_byte     = r_pend_valid ? r_pend_byte : rx_if.rx_byte;
    assign w_busy     = (r_state != ST_IDLE) && (r_state != ST_CHECK);
    assign w_timeout  = w_busy && !w_valid && (r_timer == TMW'(TIMEOUT_CYCLES - 1));
    assign w_crc_next = crc8_byte(r_crc, w_byte);
    assign w_is_d     = (r_cmd == CMD_THETA) || (r_cmd == CMD_BURST);
    assign w_accept   = (r_rx_crc == r_crc) && !((r_cmd == CMD_BURST) && (r_burst == 8'h00))
                        && !(w_is_d && !r_cordic_en);

    always_comb begin
        w_state       = r_state;
        w_crc         = r_crc;
        w_cmd         = r_cmd;
        w_burst       = r_burst;
        w_shift       = r_shift;
        w_cnt         = r_cnt;
        w_rx_crc      = r_rx_crc;
        w_timer       = (w_busy && !w_valid) ? r_timer + 1'b1 : '0;
        w_pend_valid  = (r_state == ST_CHECK) && rx_if.rx_byte_valid;
        w_pend_byte   = w_pend_valid ? rx_if.rx_byte : r_pend_byte;
        w_cmd_reg     = r_cmd_reg;
        w_burst_cnt   = r_burst_cnt;
        w_theta       = r_theta;
        w_cordic_en   = r_cordic_en;
        w_cmd_valid   = 1'b0;
        w_burst_valid = 1'b0;
        w_theta_valid = 1'b0;
        w_err         = 1'b0;
        case (r_state)
            ST_IDLE: if (w_valid && (w_byte == BYTE_HEADER)) begin
                w_state = ST_CMD;
                w_crc   = crc8_byte(8'h00, w_byte);
            end
            ST_CMD: if (w_valid) begin
                w_cmd = w_byte;
                w_crc = w_crc_next;
                w_cnt = '0;
                if (w_byte == CMD_THETA) w_state = ST_THETA;
                else if (w_byte == CMD_BURST) w_state = ST_BURST;
                else if ((w_byte == CMD_DISABLE) || (w_byte == CMD_ENABLE)) w_state = ST_CRC;
                else begin
                    w_state = ST_IDLE;
                    w_crc   = 8'h00;
                    w_err   = 1'b1;
                end
            end
            ST_BURST: if (w_valid) begin
                w_burst = w_byte;
                w_crc   = w_crc_next;
                w_state = ST_THETA;
            end
            ST_THETA: if (w_valid) begin
                w_shift = {w_byte, r_shift[THW-1:8]};
                w_crc   = w_crc_next;
                w_cnt   = r_cnt + 1'b1;
                w_state = (r_cnt == CW'(THETA_BYTES - 1)) ? ST_CRC : ST_THETA;
            end
            ST_CRC: if (w_valid) begin
                w_rx_crc = w_byte;
                w_state  = ST_CHECK;
            end
            ST_CHECK: begin
                w_state = ST_IDLE;
                w_crc   = 8'h00;
                w_err   = !w_accept;
                if (w_accept) begin
                    w_cmd_valid   = 1'b1;
                    w_cmd_reg     = r_cmd;
                    w_theta_valid = w_is_d;
                    w_burst_valid = (r_cmd == CMD_BURST);
                    w_theta       = w_is_d ? r_shift : r_theta;
                    w_burst_cnt   = (r_cmd == CMD_BURST) ? r_burst : r_burst_cnt;
                    w_cordic_en   = (r_cmd == CMD_ENABLE) ? 1'b1 : (r_cmd == CMD_DISABLE) ? 1'b0 : r_cordic_en;
                end
            end
            default: w_state = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_state = ST_IDLE;
            w_crc   = 8'h00;
            w_err   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_crc         <= '0;
            r_cmd         <= '0;
            r_burst       <= '0;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_rx_crc      <= '0;
            r_timer       <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_byte   <= '0;
            r_cmd_reg     <= '0;
            r_burst_cnt   <= '0;
            r_theta       <= '0;
            r_cordic_en   <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_burst_valid <= 1'b0;
            r_theta_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_crc         <= w_crc;
            r_cmd         <= w_cmd;
            r_burst       <= w_burst;
            r_shift       <= w_shift;
            r_cnt         <= w_cnt;
            r_rx_crc      <= w_rx_crc;
            r_timer       <= w_timer;
            r_pend_valid  <= w_pend_valid;
            r_pend_byte   <= w_pend_byte;
            r_cmd_reg     <= w_cmd_reg;
            r_burst_cnt   <= w_burst_cnt;
            r_theta       <= w_theta;
            r_cordic_en   <= w_cordic_en;
            r_cmd_valid   <= w_cmd_valid;
            r_burst_valid <= w_burst_valid;
            r_theta_valid <= w_theta_valid;
            r_err         <= w_err;
        end
    end

    assign o_cmd_reg         = r_cmd_reg;
    assign o_cmd_valid       = r_cmd_valid;
    assign o_burst_cnt       = r_burst_cnt;
    assign o_burst_cnt_valid = r_burst_valid;
    assign o_theta           = r_theta;
    assign o_theta_valid     = r_theta_valid;
    assign o_cordic_en       = r_cordic_en;
    assign o_rx_msg_err      = r_err;

endmodule

// File: tb/tb_uart_rx_msg_parser.sv
// tb_uart_rx_msg_parser: directed byte streams with a scoreboard checked on every output pulse
module tb_uart_rx_msg_parser;

    localparam int T = 64;

    typedef struct {
        bit          err;
        logic [7:0]  cmd;
        logic [7:0]  burst;
        bit          bv;
        logic [47:0] theta;
        bit          tv;
        bit          en;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cmd_reg, burst_cnt;
    logic [47:0] theta;
    logic        cmd_valid, burst_valid, theta_valid, cordic_en, err;
    int          checks = 0, failures = 0, cyc = 0, last_drive = 0;
    exp_t        q[$];
    logic [7:0]  m_cmd, m_burst;
    logic [47:0] m_theta;
    bit          m_en;

    uart_rx_msg_parser_if rx_if();

    uart_rx_msg_parser #(.TIMEOUT_CYCLES(T), .THETA_BYTES(6)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .rx_if(rx_if),
        .o_cmd_reg(cmd_reg), .o_cmd_valid(cmd_valid),
        .o_burst_cnt(burst_cnt), .o_burst_cnt_valid(burst_valid),
        .o_theta(theta), .o_theta_valid(theta_valid),
        .o_cordic_en(cordic_en), .o_rx_msg_err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bit-serial form of the CRC8 (poly 0x9B) used to build reference checksums
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h9B : 8'h00);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_if.rx_byte       = b;
        rx_if.rx_byte_valid = 1'b1;
        last_drive          = cyc;
        @(posedge clk);
        #1 rx_if.rx_byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [71:0] bytes, input int n, input bit add_crc);
        logic [7:0] c, b;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            b = bytes[8*(n-1-i) +: 8];
            c = crc_step(c, b);
            if (i > 0) @(posedge clk);
            send_byte(b);
        end
        if (add_crc) begin
            @(posedge clk);
            send_byte(c);
        end
    endtask

    task automatic push(input bit e_err, input bit bv, input bit tv, input int lat);
        exp_t e;
        e.err = e_err; e.cmd = m_cmd; e.burst = m_burst; e.bv = bv;
        e.theta = m_theta; e.tv = tv; e.en = m_en; e.cyc = last_drive + lat;
        q.push_back(e);
    endtask

    task automatic exp_ok(input logic [7:0] c, input logic [7:0] bc, input logic [47:0] th);
        m_cmd = c;
        if (c == 8'hD2) m_burst = bc;
        if (c == 8'hD1 || c == 8'hD2) m_theta = th;
        if (c == 8'hE1) m_en = 1'b0;
        if (c == 8'hE2) m_en = 1'b1;
        push(1'b0, c == 8'hD2, c == 8'hD1 || c == 8'hD2, 2);
    endtask

    task automatic exp_err(input int lat);
        push(1'b1, 1'b0, 1'b0, lat);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (cmd_valid || err || theta_valid || burst_valid)) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", {cmd_valid, err, theta_valid, burst_valid}, 0);
                end else begin
                    e = q.pop_front();
                    check("err_pulse", err, e.err);
                    check("cmd_valid", cmd_valid, !e.err);
                    check("burst_valid", burst_valid, e.bv);
                    check("theta_valid", theta_valid, e.tv);
                    check("cmd_reg", cmd_reg, e.cmd);
                    check("burst_cnt", burst_cnt, e.burst);
                    check("theta", theta, e.theta);
                    check("cordic_en", cordic_en, e.en);
                    check("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    endtask

    task automatic run();
        rx_if.rx_byte = 8'h00; rx_if.rx_byte_valid = 1'b0; rst_n = 1'b0;
        m_cmd = 0; m_burst = 0; m_theta = 0; m_en = 0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", {cmd_reg, burst_cnt, cmd_valid, burst_valid, theta_valid, cordic_en, err}, 0);
        check("reset_theta", theta, 0);
        @(negedge clk) rst_n = 1'b1;
        idle(2);
        send_frame(72'h5AE2, 2, 1); exp_ok(8'hE2, 0, 0); idle(4);
        send_frame(72'h5AE1, 2, 1); exp_ok(8'hE1, 0, 0); idle(4);
        send_frame(72'h5AE2, 2, 1); exp_ok(8'hE2, 0, 0); idle(4);
        send_frame(72'h5AD1010203040506, 8, 1); exp_ok(8'hD1, 0, 48'h060504030201); idle(4);
        send_frame(72'h5AD20411223344555A, 9, 1); exp_ok(8'hD2, 8'h04, 48'h5A5544332211); idle(4);
        send_frame(72'h5AD20011223344555A, 9, 1); exp_err(2); idle(4);
        send_frame(72'h5AE200, 3, 0); exp_err(2); idle(4);
        send_frame(72'h5A77, 2, 0); exp_err(1); idle(4);
        send_frame(72'h5AE2, 2, 1); exp_ok(8'hE2, 0, 0); idle(4);
        send_frame(72'h5AD1010203, 5, 0); exp_err(1 + T); idle(T + 4);
        send_frame(72'h1122, 2, 0); idle(4);
        send_frame(72'h5AE1, 2, 1); exp_ok(8'hE1, 0, 0); idle(4);
        send_frame(72'h5AD1A1A2A3A4A5A6, 8, 1); exp_err(2); idle(4);
        send_frame(72'hAA00, 2, 0); idle(2);
        send_frame(72'h5AE2, 2, 1); exp_ok(8'hE2, 0, 0); idle(4);
        send_frame(72'h5AE1, 2, 1); exp_ok(8'hE1, 0, 0);
        send_frame(72'h5AE2, 2, 1); exp_ok(8'hE2, 0, 0); idle(4);
        send_frame(72'h5AD10102, 4, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_ctrl", {cmd_reg, burst_cnt, cmd_valid, burst_valid, theta_valid, cordic_en, err}, 0);
        check("midreset_theta", theta, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_cmd = 0; m_burst = 0; m_theta = 0; m_en = 0;
        idle(2);
        send_frame(72'h5AE2, 2, 1); exp_ok(8'hE2, 0, 0); idle(6);
        check("queue_drained", q.size(), 0);
    endtask

    initial begin
        fork
            monitor();
            run();
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
